// File: rtl/jtcontra_snd_pkg.sv
// ----------------------------------------------------------------------------
// jtcontra_snd_pkg
// Shared constants for the Contra sound output conditioning stage:
//   - unity gain code and maximum volume of the power-up/mute ramp
//   - 16-bit saturation limits
//   - indices into the valid shift register, one per pipeline stage
// ----------------------------------------------------------------------------
package jtcontra_snd_pkg;

    localparam logic [7:0]         GAIN_UNITY = 8'h10;   // 4.4 format, 1.0
    localparam logic [8:0]         VOL_MAX    = 9'd256;  // full volume
    localparam logic signed [15:0] SAT_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN    = 16'sh8000;

    // Valid-pipe bit set once the corresponding stage has registered a sample
    localparam int ST_MUL = 0;  // gain product and volume latched
    localparam int ST_SAT = 1;  // scaled and saturated sample
    localparam int ST_LPF = 2;  // low-pass (or bypass) output
    localparam int ST_OUT = 3;  // final volume-scaled sample

endpackage

// File: rtl/jtcontra_snd_lpf1.sv
// ----------------------------------------------------------------------------
// jtcontra_snd_lpf1
// Single-pole low-pass y += (x - y) >>> LPF_SH. When bypassed, y simply
// follows the input so that re-enabling the filter starts from the current
// signal level instead of a stale state.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        input sample valid this cycle
//   lpf_en    1: filter, 0: pass x straight through
//   x         signed 16-bit input
//   y         signed 16-bit filter state, also the stage output
// ----------------------------------------------------------------------------
module jtcontra_snd_lpf1 #(
    parameter int LPF_SH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               lpf_en,
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    logic signed [15:0] y_q, y_d;
    logic signed [16:0] diff;
    logic signed [16:0] step;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        y_d  = y_q;
        diff = {x[15], x} - {y_q[15], y_q};
        step = diff >>> LPF_SH;
        if (en) begin
            // The sum always lies between y and x, so 16 bits cannot overflow
            y_d = lpf_en ? 16'({y_q[15], y_q} + step) : x;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= '0;
        else     y_q <= y_d;
    end

    assign y = y_q;

endmodule

// File: rtl/jtcontra_snd_out.sv
// ----------------------------------------------------------------------------
// jtcontra_snd_out
// Output conditioning for the FM/PSG mixer: 4.4 gain with saturation,
// optional one-pole low-pass, click-free mute/power-up volume ramp, plus
// clip counter and decaying peak meter. Four-stage pipeline, one sample
// accepted per clock, sample_out exactly four clocks after sample.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   sample      input strobe; snd_in valid
//   snd_in      signed 16-bit input sample
//   gain        unsigned 4.4 gain, 8'h10 = 1.0
//   lpf_en      low-pass enable
//   mute        ramp volume towards 0 (high) or full (low)
//   clr         synchronous clear of clip_cnt
//   snd_out     signed output sample, held between strobes
//   sample_out  output strobe
//   clip_cnt    saturating count of clipped samples
//   peak        decaying peak magnitude
// ----------------------------------------------------------------------------
module jtcontra_snd_out
    import jtcontra_snd_pkg::*;
#(
    parameter int LPF_SH    = 2,
    parameter int RAMP_STEP = 1,
    parameter int PEAK_SH   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample,
    input  logic signed [15:0] snd_in,
    input  logic        [7:0]  gain,
    input  logic               lpf_en,
    input  logic               mute,
    input  logic               clr,
    output logic signed [15:0] snd_out,
    output logic               sample_out,
    output logic        [7:0]  clip_cnt,
    output logic        [14:0] peak
);

    logic        [3:0]  v_q, v_d;
    logic        [8:0]  vol_q, vol_d;          // running ramp volume
    logic        [8:0]  vol0_q, vol1_q, vol2_q; // volume travelling with the sample
    logic signed [24:0] p_q, p_d;
    logic signed [15:0] s_q, s_d;
    logic        [7:0]  clip_cnt_q, clip_cnt_d;
    logic signed [15:0] snd_out_q, snd_out_d;
    logic        [14:0] peak_q, peak_d;

    logic signed [20:0] s_wide;
    logic               clip;
    logic signed [15:0] lpf_y;
    logic signed [25:0] prod;
    logic        [14:0] mag;

    // S0: gain product and volume ramp step
    always_comb begin
        p_d   = snd_in * $signed({1'b0, gain});
        vol_d = vol_q;
        if (sample) begin
            if (mute) vol_d = (vol_q >= 9'(RAMP_STEP)) ? vol_q - 9'(RAMP_STEP) : '0;
            else      vol_d = (int'(vol_q) + RAMP_STEP >= int'(VOL_MAX)) ? VOL_MAX
                                                                          : vol_q + 9'(RAMP_STEP);
        end
    end

    // S1: drop the 4 fractional gain bits and saturate
    always_comb begin
        s_wide     = 21'(p_q >>> 4);
        clip       = 1'b0;
        s_d        = s_wide[15:0];
        if (s_wide > 21'sd32767) begin
            s_d  = SAT_MAX;
            clip = 1'b1;
        end else if (s_wide < -21'sd32768) begin
            s_d  = SAT_MIN;
            clip = 1'b1;
        end
        clip_cnt_d = clip_cnt_q;
        if (clr)
            clip_cnt_d = '0;
        else if (v_q[ST_MUL] && clip && clip_cnt_q != 8'hFF)
            clip_cnt_d = clip_cnt_q + 8'd1;
    end

    // S2: low-pass / bypass
    jtcontra_snd_lpf1 #(.LPF_SH(LPF_SH)) u_lpf (
        .clk    (clk),
        .rst    (rst),
        .en     (v_q[ST_SAT]),
        .lpf_en (lpf_en),
        .x      (s_q),
        .y      (lpf_y)
    );

    // S3: volume scaling and peak meter on the freshly computed sample
    always_comb begin
        prod      = lpf_y * $signed({1'b0, vol2_q});
        snd_out_d = snd_out_q;
        peak_d    = peak_q;
        mag       = '0;
        if (v_q[ST_LPF]) begin
            // vol <= 256 keeps the scaled result inside 16 bits
            snd_out_d = 16'(prod >>> 8);
            // -32768 has no positive counterpart; clamp its magnitude
            if (snd_out_d == SAT_MIN) mag = 15'h7FFF;
            else                      mag = 15'(snd_out_d[15] ? -snd_out_d : snd_out_d);
            peak_d = (mag > peak_q) ? mag : peak_q - (peak_q >> PEAK_SH);
        end
        v_d = {v_q[2:0], sample};
    end

    // NOTE: every register, including the pipeline data, is reset so a mid-stream reset leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= '0;
            vol_q      <= '0;
            vol0_q     <= '0;
            vol1_q     <= '0;
            vol2_q     <= '0;
            p_q        <= '0;
            s_q        <= '0;
            clip_cnt_q <= '0;
            snd_out_q  <= '0;
            peak_q     <= '0;
        end else begin
            v_q        <= v_d;
            vol_q      <= vol_d;
            vol0_q     <= vol_d;
            vol1_q     <= vol0_q;
            vol2_q     <= vol1_q;
            p_q        <= p_d;
            s_q        <= s_d;
            clip_cnt_q <= clip_cnt_d;
            snd_out_q  <= snd_out_d;
            peak_q     <= peak_d;
        end
    end

    assign snd_out    = snd_out_q;
    assign sample_out = v_q[ST_OUT];
    assign clip_cnt   = clip_cnt_q;
    assign peak       = peak_q;

endmodule

// File: tb/tb_jtcontra_snd_out.sv
// ----------------------------------------------------------------------------
// tb_jtcontra_snd_out
// Directed bench for jtcontra_snd_out with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_jtcontra_snd_out;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample;
    logic signed [15:0] snd_in;
    logic        [7:0]  gain;
    logic               lpf_en;
    logic               mute;
    logic               clr;
    logic signed [15:0] snd_out;
    logic               sample_out;
    logic        [7:0]  clip_cnt;
    logic        [14:0] peak;

    int total = 0;
    int bad   = 0;

    jtcontra_snd_out #(.LPF_SH(2), .RAMP_STEP(1), .PEAK_SH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample     (sample),
        .snd_in     (snd_in),
        .gain       (gain),
        .lpf_en     (lpf_en),
        .mute       (mute),
        .clr        (clr),
        .snd_out    (snd_out),
        .sample_out (sample_out),
        .clip_cnt   (clip_cnt),
        .peak       (peak)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe one sample, wait (bounded) for its output, check the latency
    task automatic send(input logic signed [15:0] x, output logic signed [15:0] y);
        int lat;
        @(negedge clk);
        sample = 1'b1;
        snd_in = x;
        @(negedge clk);
        sample = 1'b0;
        lat = 1;
        while (!sample_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        y = snd_out;
    endtask

    initial begin
        logic signed [15:0] y;
        int seen;

        rst = 1'b1; sample = 1'b0; snd_in = '0; gain = 8'h10;
        lpf_en = 1'b0; mute = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_snd_out", snd_out, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_clip_cnt", clip_cnt, 0);
        check("rst_peak", peak, 0);
        rst = 1'b0;

        // Power-up ramp from vol=0, one step per sample
        for (int i = 1; i <= 257; i++) begin
            send(16'sd1000, y);
            if (i == 1)   check("ramp_1", y, 3);
            if (i == 2)   check("ramp_2", y, 7);
            if (i == 255) check("ramp_255", y, 996);
            if (i == 256) check("ramp_256", y, 1000);
            if (i == 257) check("ramp_257", y, 1000);
        end
        check("ramp_peak", peak, 1000);
        repeat (3) @(negedge clk);
        check("hold_snd_out", snd_out, 1000);
        check("hold_strobe", sample_out, 0);

        // Saturation and clip counting
        gain = 8'hFF;
        send(16'sh4000, y);
        check("sat_pos", y, 32767);
        check("sat_pos_cnt", clip_cnt, 1);
        check("sat_pos_peak", peak, 32767);
        send(16'sh8000, y);
        check("sat_neg", y, -32768);
        check("sat_neg_cnt", clip_cnt, 2);
        check("sat_neg_peak", peak, 32736);
        // clr coincides with the clip increment at S1
        @(negedge clk); sample = 1'b1; snd_in = 16'sh4000;
        @(negedge clk); sample = 1'b0; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        seen = 0;
        while (!sample_out && seen < 20) begin @(negedge clk); seen++; end
        check("clr_snd_out", snd_out, 32767);
        check("clr_cnt", clip_cnt, 0);
        gain = 8'h10;

        // Low-pass step response from y=0
        send(16'sd0, y);
        check("lpf_zero", y, 0);
        lpf_en = 1'b1;
        send(16'sd4000, y); check("lpf_1", y, 1000);
        send(16'sd4000, y); check("lpf_2", y, 1750);
        send(16'sd4000, y); check("lpf_3", y, 2312);
        send(16'sd4000, y); check("lpf_4", y, 2734);
        lpf_en = 1'b0;
        send(16'sd4000, y); check("lpf_off", y, 4000);
        check("lpf_clip_cnt", clip_cnt, 0);

        // Mute ramp with reversal at sample 100
        mute = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            send(16'sd2560, y);
            if (i == 1)   check("mute_1", y, 2550);
            if (i == 100) check("mute_100", y, 1560);
        end
        mute = 1'b0;
        send(16'sd2560, y);
        check("unmute", y, 1570);
        mute = 1'b1;
        for (int i = 1; i <= 157; i++) begin
            send(16'sd2560, y);
            if (i == 156) check("mute_tail", y, 10);
            if (i == 157) check("mute_zero", y, 0);
        end
        send(16'sd2560, y);
        check("mute_floor", y, 0);
        mute = 1'b0;

        // Reset while a sample is in flight
        @(negedge clk); sample = 1'b1; snd_in = 16'sd2560;
        @(negedge clk); sample = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_snd_out", snd_out, 0);
        check("mid_rst_clip", clip_cnt, 0);
        check("mid_rst_peak", peak, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sample_out) seen++;
        end
        check("mid_rst_no_strobe", seen, 0);
        send(-16'sd1000, y);
        check("post_rst_vol1", y, -4);

        // Bring vol back to full with silence, then back-to-back strobes
        for (int i = 0; i < 255; i++) send(16'sd0, y);
        check("silence_peak", peak, 4);
        @(negedge clk); sample = 1'b1; snd_in = 16'sd10;
        @(negedge clk); snd_in = 16'sd20;
        @(negedge clk); snd_in = 16'sd30;
        @(negedge clk); snd_in = 16'sd40;
        @(negedge clk); sample = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("b2b_strobe", sample_out, 1);
            check("b2b_value", snd_out, 10 * i);
            @(negedge clk);
        end
        check("b2b_end", sample_out, 0);
        check("b2b_peak", peak, 40);
        send(16'sd0, y);
        check("b2b_zero", y, 0);
        check("b2b_peak_decay", peak, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtcontra_snd_out.md
Name: jtcontra_snd_out

Overview:
- Sound output conditioning stage directly downstream of the Contra sound board's FM/PSG mixer.
- Consumes the mixer's signed 16-bit sample together with its `sample` strobe.
- Applies programmable gain with saturation, an optional first-order low-pass, and a click-free mute/power-up volume ramp.
- Produces the final sample stream for the platform audio output, plus clip and peak status for the debug/OSD path.

Parameters:
- LPF_SH, 2: low-pass shift; coefficient is 2^-LPF_SH.
- RAMP_STEP, 1: volume change per accepted input sample (0..256 scale).
- PEAK_SH, 10: peak-meter decay shift per output sample.

Ports:
- clk  in  1: system clock, 24 MHz.
- rst  in  1: reset.
- sample  in  1: one-clk input strobe, from the mixer's sample output.
- snd_in  in  16: signed input sample; valid when sample=1.
- gain  in  8: unsigned 4.4 gain; 8'h10 = 1.0.
- lpf_en  in  1: enables the low-pass.
- mute  in  1: level; ramps volume to 0 while high, to 256 while low.
- clr  in  1: synchronous clear of clip_cnt.
- snd_out  out  16: signed output sample.
- sample_out  out  1: one-clk strobe; snd_out is valid in that cycle and held until the next strobe.
- clip_cnt  out  8: saturating count of clipped samples.
- peak  out  15: decaying peak magnitude.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all registers clear while rst=1: snd_out=0, sample_out=0, clip_cnt=0, peak=0, LPF state y=0, volume vol=0, valid pipe=0.
  - Because vol starts at 0, output always ramps up from silence after reset.
  - Asserting rst mid-pipeline discards in-flight samples; no sample_out is emitted for them.
- Pipeline: fully pipelined, accepts a sample on every clk. Valid shift register v[3:0]. sample_out=v[3], i.e. exactly 4 clk after the sample strobe. Order is preserved.
- S0, on sample:
  - p = snd_in × {1'b0,gain}, signed 25-bit.
  - Update vol: if mute, vol=max(vol−RAMP_STEP,0); else vol=min(vol+RAMP_STEP,256).
  - Latch the new vol alongside the sample.
- S1:
  - s = p>>>4 (arithmetic).
  - Saturate to [−32768, 32767].
  - If clipping occurred, clip_cnt increments unless it is already 255.
  - clr takes priority over a simultaneous increment (result 0).
- S2:
  - If lpf_en: d = s − y in 17 bits; y = y + (d>>>LPF_SH); stage output = y.
  - Else: y = s and stage output = s, so toggling lpf_en causes no jump.
- S3:
  - snd_out = (stage2 × vol)>>>8, computed at 26 bits and truncated to 16 (cannot overflow since vol≤256).
  - Peak update on the same cycle: a = |snd_out|, with −32768 mapped to 32767.
    - If a > peak: peak = a.
    - Else: peak = peak − (peak>>PEAK_SH).
- mute is sampled only at S0, so toggling it mid-ramp reverses the ramp from the current vol.
- gain and lpf_en are sampled at the stage that uses them; no glitch protection is required.
- All arithmetic is signed two's complement; >>> floors toward −∞.

Decomposition:
- Shared package jtcontra_snd_pkg holds:
  - GAIN_UNITY=8'h10, VOL_MAX=9'd256
  - SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000
  - stage index constants for v[]
- One natural sub-module: jtcontra_snd_lpf1. It holds the single-pole filter with its enable/bypass tracking (y register, 17-bit difference, shift by LPF_SH) and is instantiated at S2.

Test Plan:
- Power-up ramp. After rst release: gain=8'h10, lpf_en=0, mute=0, RAMP_STEP=1, constant snd_in=1000 strobed every 430 clk.
  - First sample_out comes 4 clk after the strobe, with snd_out=3 (1000×1>>8).
  - The 256th output and later equal 1000.
  - snd_in=−1000 at vol=1 gives −4.
- Saturation. vol=256, gain=8'hFF, snd_in=16'h4000 → snd_out=32767, clip_cnt=1. Then snd_in=16'h8000 → −32768, clip_cnt=2. clr with a simultaneous clip → clip_cnt=0.
- Low-pass. vol=256, gain=8'h10, lpf_en=1, LPF_SH=2, y=0, input steps to 4000 → outputs 1000, 1750, 2312, 2734. Dropping lpf_en gives 4000 on the next output.
- Mute. vol=256, mute=1 → outputs fall by snd_in/256 per sample and reach 0 after 256 samples. Releasing mute at sample 100 restarts the rise from vol=156, with no discontinuity.
- Back-to-back strobes. sample high on 4 consecutive clk with inputs 10, 20, 30, 40 at unity/full vol → sample_out high on 4 consecutive clk with 10, 20, 30, 40. Then peak=40, decaying to 40−0=40 (40>>10=0).
- Mid-pipeline reset. Strobe, then rst asserted asynchronously 2 clk later → no sample_out; snd_out=0, vol=0, clip_cnt=0, peak=0. The next post-reset sample outputs at vol=1.
